// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard/flush controller for an NSTAGE-deep core: stall and redirect arbitration,
// precise interrupt entry (drain, EPC, trap vector), ERET return and a stall watchdog.
module pipe_hazard_unit #(
  parameter int              NSTAGE     = 5,
  parameter int              AW         = 32,
  parameter logic [AW-1:0]   TRAP_VEC   = AW'(32'h0000_0008),
  parameter int              ERET_STAGE = 1,
  parameter int              MAX_WAIT   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NSTAGE-1:0]    stall_req,
  input  logic [NSTAGE-1:0]    redir_vld,
  input  logic [NSTAGE*AW-1:0] redir_addr,
  input  logic                 eret_vld,
  input  logic                 int_req,
  input  logic                 int_en,
  input  logic [AW-1:0]        fetch_pc,
  output logic [NSTAGE-1:0]    stop,
  output logic [NSTAGE-1:0]    flush,
  output logic                 pc_redir_vld,
  output logic [AW-1:0]        pc_redir_addr,
  output logic [AW-1:0]        epc,
  output logic                 in_trap,
  output logic                 int_ack,
  output logic                 stall_timeout,
  output logic [1:0]           fsm_state
);

  localparam int CW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
  localparam int WW = $clog2(MAX_WAIT + 2);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_TRAP  = 2'd2;

  logic [1:0]        state;
  logic [CW-1:0]     drain_cnt;
  logic [CW-1:0]     drain_cnt_nxt;
  logic [WW-1:0]     wd_cnt;

  logic              stall_any;
  int                s_idx;
  int                r_idx;
  logic [NSTAGE-1:0] redir_all;
  logic [AW-1:0]     r_tgt;
  logic              eret_live;
  logic              redir_ok;
  logic              eret_taken;
  logic              enter;
  logic [NSTAGE-1:0] stall_stop;
  logic [NSTAGE-1:0] stall_flush;
  logic [NSTAGE-1:0] redir_flush;

  assign fsm_state     = state;
  assign drain_cnt_nxt = drain_cnt + 1'b1;

  // Arbitration. Index -1 means "no request". ERET joins the redirect vector at
  // ERET_STAGE, and only counts while a handler is actually active.
  always_comb begin
    eret_live = eret_vld && in_trap && (state == ST_RUN);
    redir_all = redir_vld;
    if (eret_live) redir_all[ERET_STAGE] = 1'b1;
    stall_any = |stall_req;
    s_idx     = -1;
    r_idx     = -1;
    r_tgt     = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      if (stall_req[k]) s_idx = k;
      if (redir_all[k]) begin
        r_idx = k;
        if (k == ERET_STAGE && eret_live) r_tgt = epc;
        else                              r_tgt = redir_addr[k*AW +: AW];
      end
    end
    redir_ok   = (r_idx >= 0) && (s_idx < r_idx);
    eret_taken = redir_ok && eret_live && (r_idx == ERET_STAGE);
    for (int j = 0; j < NSTAGE; j++) begin
      stall_stop[j]  = (j <= s_idx);
      stall_flush[j] = (j >= 1) && (j == s_idx + 1);
      redir_flush[j] = (j >= 1) && (j <= r_idx);
    end
    enter = (state == ST_RUN) && int_req && int_en && !in_trap &&
            !stall_any && !(|redir_vld);
  end

  // Output steering. During DRAIN the PC stays frozen: an applied redirect only
  // kills the younger stages and retargets epc, the trap vector loads the PC later.
  always_comb begin
    stop          = '0;
    flush         = '0;
    pc_redir_vld  = 1'b0;
    pc_redir_addr = r_tgt;
    int_ack       = 1'b0;
    stall_timeout = 1'b0;
    if (reset) begin
      flush = {{(NSTAGE-1){1'b1}}, 1'b0};
    end else begin
      stall_timeout = stall_any && (wd_cnt == WW'(MAX_WAIT));
      if (state == ST_TRAP) begin
        flush[1]      = 1'b1;
        pc_redir_vld  = 1'b1;
        pc_redir_addr = TRAP_VEC;
        int_ack       = 1'b1;
      end else begin
        if (redir_ok) begin
          flush        = redir_flush;
          pc_redir_vld = (state == ST_RUN);
        end else begin
          stop  = stall_stop;
          flush = stall_flush;
        end
        if (state == ST_DRAIN) begin
          stop[0]  = 1'b1;
          flush[1] = 1'b1;
        end
      end
      flush[0] = 1'b0;
    end
  end

  // Watchdog: counts consecutive stalled cycles, pulses and restarts at MAX_WAIT+1.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (!stall_any) begin
      wd_cnt <= '0;
    end else if (wd_cnt == WW'(MAX_WAIT)) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Interrupt FSM: RUN -> DRAIN (let older stages retire) -> TRAP (one cycle) -> RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_RUN;
      epc       <= '0;
      in_trap   <= 1'b0;
      drain_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (eret_taken) in_trap <= 1'b0;
          if (enter) begin
            state     <= ST_DRAIN;
            epc       <= fetch_pc;
            drain_cnt <= '0;
          end
        end
        ST_DRAIN: begin
          if (redir_ok) epc <= r_tgt;
          if (!stall_any) begin
            drain_cnt <= drain_cnt_nxt;
            if (drain_cnt_nxt == CW'(NSTAGE - 1)) state <= ST_TRAP;
          end
        end
        ST_TRAP: begin
          in_trap <= 1'b1;
          state   <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule
